// File: rtl/lzd_pkg.sv
// Shared constants for the leading-zero-detect datapath (LZD_48, normalizer, denormalizer).
// Changing DATA_W here retargets every block that defaults to these values.
package lzd_pkg;

  localparam int DATA_W  = 48;
  localparam int POS_W   = 6;
  localparam int ZERO_LZ = DATA_W;

  // Smallest power of two that covers w bits; the LZC tree is built at this width.
  function automatic int tree_width(input int w);
    return 1 << $clog2(w);
  endfunction

endpackage

// File: rtl/lzc_priority.sv
// Combinational leading-zero counter built as a binary tree of 2-bit leaves.
// The input is left-aligned into a power-of-two width; an all-zero word reports DATA_W.
module lzc_priority #(
  parameter int DATA_W = lzd_pkg::DATA_W,
  parameter int POS_W  = lzd_pkg::POS_W
) (
  input  logic [DATA_W-1:0] data,
  output logic [POS_W-1:0]  lz,
  output logic              zero
);

  localparam int PAD_W = lzd_pkg::tree_width(DATA_W);
  localparam int LVLS  = $clog2(PAD_W);

  // Zero padding sits below the real LSB, so it never changes a nonzero count.
  logic [PAD_W-1:0] padded;
  assign padded = PAD_W'(data) << (PAD_W - DATA_W);

  genvar gi, gj;
  generate
    for (gi = 0; gi < LVLS; gi++) begin : lvl
      localparam int NODES = PAD_W >> (gi + 1);
      logic [gi:0] node_cnt  [NODES];
      logic        node_zero [NODES];

      for (gj = 0; gj < NODES; gj++) begin : node
        if (gi == 0) begin : g_leaf
          assign node_zero[gj] = ~(padded[2*gj+1] | padded[2*gj]);
          assign node_cnt[gj]  = ~padded[2*gj+1];
        end else begin : g_merge
          // Odd child covers the upper half; fall through to the lower half only when it is empty.
          assign node_zero[gj] = lvl[gi-1].node_zero[2*gj+1] & lvl[gi-1].node_zero[2*gj];
          assign node_cnt[gj]  = lvl[gi-1].node_zero[2*gj+1]
                               ? {1'b1, lvl[gi-1].node_cnt[2*gj]}
                               : {1'b0, lvl[gi-1].node_cnt[2*gj+1]};
        end
      end
    end
  endgenerate

  assign zero = lvl[LVLS-1].node_zero[0];
  assign lz   = zero ? POS_W'(DATA_W) : POS_W'(lvl[LVLS-1].node_cnt[0]);

endmodule

// File: rtl/lzd_normalizer.sv
// Three-stage mantissa normalizer: capture, leading-zero count, barrel shift.
// One global advance signal moves every stage together, giving full backpressure.
module lzd_normalizer #(
  parameter int DATA_W = lzd_pkg::DATA_W,
  parameter int POS_W  = lzd_pkg::POS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [POS_W-1:0]  out_lz,
  output logic              out_zero
);

  logic              adv;
  logic              s1_valid_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic              s2_valid_reg;
  logic [DATA_W-1:0] s2_data_reg;
  logic [POS_W-1:0]  s2_lz_reg;
  logic              s2_zero_reg;
  logic [POS_W-1:0]  lz_next;
  logic              zero_next;
  logic [DATA_W-1:0] shift_stage [POS_W+1];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  lzc_priority #(
    .DATA_W (DATA_W),
    .POS_W  (POS_W)
  ) u_lzc (
    .data (s1_data_reg),
    .lz   (lz_next),
    .zero (zero_next)
  );

  // Log-shifter: stage gi shifts by 2**gi when bit gi of the count is set.
  assign shift_stage[0] = s2_data_reg;
  genvar gi;
  generate
    for (gi = 0; gi < POS_W; gi++) begin : g_shift
      assign shift_stage[gi+1] = s2_lz_reg[gi] ? (shift_stage[gi] << (1 << gi))
                                               : shift_stage[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_lz_reg    <= '0;
      s2_zero_reg  <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_lz       <= '0;
      out_zero     <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      // Holding the last word through bubbles keeps the output fields steady.
      if (in_valid) begin
        s1_data_reg <= in_data;
      end
      s2_valid_reg <= s1_valid_reg;
      s2_data_reg  <= s1_data_reg;
      s2_lz_reg    <= lz_next;
      s2_zero_reg  <= zero_next;
      out_valid    <= s2_valid_reg;
      out_data     <= shift_stage[POS_W];
      out_lz       <= s2_lz_reg;
      out_zero     <= s2_zero_reg;
    end
  end

endmodule

// File: doc/lzd_normalizer.md
Name: lzd_normalizer

Overview:
Pipelined mantissa normalizer. It sits on the consumer side of the leading-zero-detect path in the Gaussian noise datapath. Each accepted 48-bit word is left-justified so its leading one lands at bit DATA_W-1. The block also returns the leading-zero count, for exponent/log-table indexing, plus a zero flag. Uses a valid/ready handshake on both sides and a 3-stage pipeline with full backpressure.

Parameters:
DATA_W, 48, input/output data width
POS_W, 6, width of leading-zero count; must hold DATA_W (48 needs 6 bits)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word present
in_ready  out  1  block can accept this cycle
in_data  in  DATA_W  word to normalize
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  in_data << out_lz, zero-filled from LSB
out_lz  out  POS_W  leading zeros of in_data, 0..DATA_W
out_zero  out  1  in_data was all zeros

Behaviour:
- Reset is asynchronous and active-low, applied on the rst_n falling edge, independent of clk. It clears every stage valid bit, out_valid=0, out_data=0, out_lz=0, out_zero=0. in_ready reads 1 while rst_n=0 and after release. In-flight words are discarded. No partial result may appear after reset.
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
- When adv=1, all stages shift one place on the clock edge. When adv=0, all stage registers hold. Bubbles are not collapsed.
- S1 (capture): on adv, v1<=in_valid and d1<=in_data. d1 loads only when in_valid=1.
- S2 (count): on adv, v2<=v1, d2<=d1, lz2<=lzc(d1), z2<=(d1==0).
  - lzc is a priority encoder: index of the first 1 counted from the MSB; DATA_W if d1 is zero.
- S3 (shift/output): on adv, out_valid<=v2, out_data<=d2<<lz2, out_lz<=lz2, out_zero<=z2.
  - Zero input yields out_data=0, out_lz=DATA_W, out_zero=1.
  - Shift amount is never greater than DATA_W. A shift of DATA_W yields 0, with no wrap and no X.
- Latency: a word accepted on edge N shows out_valid=1 after edge N+2 (3 register stages). Throughput is 1 word/cycle when out_ready=1.
- Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output). Each word is delivered exactly once, in order.
- Backpressure: while out_valid=1 and out_ready=0, the outputs and all stages hold stable and in_ready=0.
  - in_valid and in_data may change while in_ready=0 without effect.
- When out_ready falls and rises again, no word is duplicated or lost. The pipeline capacity is 3 words.
- Simultaneous accept and deliver in one cycle is legal and required for full rate.
- Output fields only change on an edge with adv=1. Outputs are never driven combinationally from in_data.

Decomposition:
- Shared package (lzd_pkg): DATA_W=48, POS_W=6, and a ZERO_LZ constant equal to DATA_W. The same package serves LZD_48, this block, and any denormalizer.
- One sub-module, lzc_priority: a combinational DATA_W to POS_W leading-zero counter with a zero flag, instantiated in S2. Implement it as a tree (2-bit leaves merged upward) to close timing at the datapath clock.
- The barrel shift stays inline in S3, as log2 stages of muxes in one cycle.

Test Plan:
- out_ready=1; inputs 48'h800000000000, 48'h400000000000, 48'h000000000001, 48'h000000000005 back-to-back -> out_lz 0, 1, 47, 45. out_data 48'h800000000000, 48'h800000000000, 48'h800000000000, 48'hA00000000000. Results arrive on consecutive cycles starting 3 edges after the first accept.
- in_data=0 -> out_zero=1, out_lz=48, out_data=0. Next input 48'h000000000025 -> out_lz=42, out_data=48'h940000000000, out_zero=0.
- Send 5 words with out_ready held 0 -> in_ready drops after 3 accepts. Outputs stay stable on word 1. Then raise out_ready -> all 5 words emerge in order, none lost or duplicated.
- Toggle out_ready randomly every cycle over 200 random words -> output stream equals a reference model (lzc, shift) in order.
- Assert rst_n=0 mid-stream between edges with 3 words in flight -> out_valid=0 immediately, before the next edge. After release, only words accepted post-reset appear.
- in_valid=0 gaps (accept, idle, idle, accept) -> out_valid shows matching bubbles. Output fields are unchanged during bubbles.
